xor_cipher_decrypt: RTL and testbench

Receive-side counterpart of the keyed LFSR keystream generator. It accepts a framed ciphertext byte stream over a valid/ready handshake, regenerates the same keystream from the shared per-frame key, and emits plaintext over a registered valid/ready output. The LFSR advances only when a byte is accepted, so back-pressure never desynchronises the keystream. It sits between the link receiver and the plaintext consumer.

---
 rtl/xor_cipher_decrypt_if.sv | 10 +
 rtl/xor_cipher_decrypt.sv | 140 ++++++++++++++
 tb/tb_xor_cipher_decrypt.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_cipher_decrypt_if.sv
// Byte stream channel with valid/ready handshake and an end-of-frame marker.
interface xor_cipher_decrypt_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/xor_cipher_decrypt.sv
// Receive-side keyed LFSR stream decryptor. Regenerates the transmitter's
// keystream from the per-frame key and XORs it onto each accepted ciphertext
// byte. The LFSR steps only on input acceptance, so output stalls never
// desynchronise the keystream.
module xor_cipher_decrypt #(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_load_i,
    input  logic [7:0]           key_i,
    xor_cipher_decrypt_if.slave  s_if,
    xor_cipher_decrypt_if.master m_if,
    output logic                 frame_done_o,
    output logic [CNT_W-1:0]     byte_count_o,
    output logic                 len_err_o,
    output logic                 key_err_o
);

    typedef enum logic [1:0] {IDLE, ARMED, STREAM} state_t;

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic             frame_done_q, frame_done_d;
    logic             len_err_q, len_err_d;
    logic             key_err_q, key_err_d;

    logic [7:0]       lfsr_step;
    logic [7:0]       key_seed;
    logic             s_ready;
    logic             accept;
    logic             out_hs;

    // Keystream step, key seeding and the input handshake.
    always_comb begin
        lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        key_seed  = (key_i == 8'h00) ? 8'h01 : key_i;
        s_ready   = ((state_q == ARMED) || (state_q == STREAM)) && !key_load_i
                    && (!m_valid_q || m_if.ready);
        accept    = s_if.valid && s_ready;
        out_hs    = m_valid_q && m_if.ready;
    end

    // Next-state logic: key handling, byte acceptance and output register.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        len_err_d    = len_err_q;
        key_err_d    = key_err_q;
        frame_done_d = out_hs && m_last_q;

        // Output slot empties on handshake; a same-cycle accept refills it below.
        if (out_hs) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (key_load_i) begin
                    lfsr_d  = key_seed;
                    cnt_d   = '0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (key_load_i) begin
                    lfsr_d = key_seed;
                end
            end
            STREAM: begin
                if (key_load_i) begin
                    key_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // accept is impossible while key_load_i is high, so it never races a reload.
        if (accept) begin
            if (cnt_q < MAX_LEN_C) begin
                m_data_d  = s_if.data ^ lfsr_q;
                m_last_d  = s_if.last;
                m_valid_d = 1'b1;
            end else begin
                len_err_d = 1'b1;
            end
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            lfsr_d  = lfsr_step;
            state_d = s_if.last ? IDLE : STREAM;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= 8'h01;
            cnt_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= 8'h00;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            key_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the same pre-edge values.
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            len_err_q    <= len_err_d;
            key_err_q    <= key_err_d;
        end
    end

    assign s_if.ready   = s_ready;
    assign m_if.valid   = m_valid_q;
    assign m_if.data    = m_data_q;
    assign m_if.last    = m_last_q;
    assign frame_done_o = frame_done_q;
    assign byte_count_o = cnt_q;
    assign len_err_o    = len_err_q;
    assign key_err_o    = key_err_q;

endmodule

// File: tb/tb_xor_cipher_decrypt.sv
// Directed bench for xor_cipher_decrypt: table-driven frames plus hand-written
// stall, key-priority, length-overflow and mid-frame reset sequences.
module tb_xor_cipher_decrypt;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0;            // 0: default DUT, 1: MAX_LEN=4 DUT
    logic       drv_key_load = 1'b0;
    logic [7:0] drv_key = 8'h00;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       drv_last = 1'b0;
    logic       drv_mready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    xor_cipher_decrypt_if s_a ();
    xor_cipher_decrypt_if m_a ();
    xor_cipher_decrypt_if s_b ();
    xor_cipher_decrypt_if m_b ();

    logic        fd_a, fd_b, le_a, le_b, ke_a, ke_b;
    logic [15:0] bc_a, bc_b;

    assign s_a.valid = drv_valid & ~sel;
    assign s_a.data  = drv_data;
    assign s_a.last  = drv_last;
    assign m_a.ready = drv_mready;
    assign s_b.valid = drv_valid & sel;
    assign s_b.data  = drv_data;
    assign s_b.last  = drv_last;
    assign m_b.ready = drv_mready;

    xor_cipher_decrypt #(.MAX_LEN(256), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .key_load_i(drv_key_load & ~sel), .key_i(drv_key),
        .s_if(s_a), .m_if(m_a),
        .frame_done_o(fd_a), .byte_count_o(bc_a), .len_err_o(le_a), .key_err_o(ke_a)
    );

    xor_cipher_decrypt #(.MAX_LEN(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset),
        .key_load_i(drv_key_load & sel), .key_i(drv_key),
        .s_if(s_b), .m_if(m_b),
        .frame_done_o(fd_b), .byte_count_o(bc_b), .len_err_o(le_b), .key_err_o(ke_b)
    );

    wire        mon_sready = sel ? s_b.ready : s_a.ready;
    wire        mon_mv     = sel ? m_b.valid : m_a.valid;
    wire [7:0]  mon_md     = sel ? m_b.data  : m_a.data;
    wire        mon_ml     = sel ? m_b.last  : m_a.last;
    wire        mon_fd     = sel ? fd_b : fd_a;
    wire [15:0] mon_bc     = sel ? bc_b : bc_a;
    wire        mon_le     = sel ? le_b : le_a;
    wire        mon_ke     = sel ? ke_b : ke_a;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor: captures handshaken bytes, checks frame_done timing and,
    // when enabled, output stability and s_ready during stalls.
    logic [7:0] got_data [$];
    logic       got_last [$];
    int         fd_cnt = 0;
    logic       prev_last_hs = 1'b0;
    logic       stall_chk = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_md = 8'h00;
    logic       prev_ml = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_last_hs = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            if (mon_mv && drv_mready) begin
                got_data.push_back(mon_md);
                got_last.push_back(mon_ml);
            end
            if (mon_fd || prev_last_hs) check("frame_done_timing", mon_fd, prev_last_hs);
            if (mon_fd) fd_cnt++;
            if (stall_chk) begin
                if (prev_stall) begin
                    check("stall_data_hold", mon_md, prev_md);
                    check("stall_last_hold", mon_ml, prev_ml);
                end
                if (mon_mv && !drv_mready) check("stall_s_ready_low", mon_sready, 1'b0);
            end
            prev_stall   = mon_mv && !drv_mready;
            prev_md      = mon_md;
            prev_ml      = mon_ml;
            prev_last_hs = mon_mv && drv_mready && mon_ml;
        end
    end

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic load_key(input logic [7:0] k);
        drv_key_load = 1'b1;
        drv_key      = k;
        @(posedge clk); #1;
        drv_key_load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int waitc = 0;
        drv_valid = 1'b1;
        drv_data  = d;
        drv_last  = last;
        @(negedge clk);
        while (!mon_sready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("send_s_ready", mon_sready, 1'b1);
        @(posedge clk); #1;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    task automatic clear_capture();
        got_data.delete();
        got_last.delete();
        fd_cnt = 0;
    endtask

    // exp holds byte 0 in bits [47:40]; final_last says whether the last
    // captured byte must carry m_last (no other byte may).
    task automatic check_out(input string nm, input logic [47:0] exp, input int n,
                             input logic final_last);
        check({nm, "_count"}, got_data.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_data.size()) begin
                check($sformatf("%s_data%0d", nm, i), got_data[i], exp[47-8*i -: 8]);
                check($sformatf("%s_last%0d", nm, i), got_last[i],
                      (final_last && i == n - 1) ? 1'b1 : 1'b0);
            end
        end
    endtask

    typedef struct packed {
        logic [7:0]  key;
        logic [7:0]  len;
        logic [47:0] cipher;
        logic [47:0] plain;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{8'h01, 8'd6, 48'h000000000000, 48'h010204081123};
        vecs[1] = '{8'hA5, 8'd4, 48'hFFFFFFFF0000, 48'h5AB56AD50000};
        vecs[2] = '{8'h00, 8'd4, 48'h000000000000, 48'h010204080000};
        vecs[3] = '{8'h3C, 8'd4, 48'h123456780000, 48'h2E4DA59F0000};

        // Reset values while reset is held.
        @(negedge clk);
        check("rst_s_ready",    mon_sready, 1'b0);
        check("rst_m_valid",    mon_mv, 1'b0);
        check("rst_m_data",     mon_md, 8'h00);
        check("rst_m_last",     mon_ml, 1'b0);
        check("rst_frame_done", mon_fd, 1'b0);
        check("rst_byte_count", mon_bc, 16'd0);
        check("rst_len_err",    mon_le, 1'b0);
        check("rst_key_err",    mon_ke, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven frames at full throughput.
        for (int v = 0; v < 4; v++) begin
            clear_capture();
            load_key(vecs[v].key);
            for (int i = 0; i < int'(vecs[v].len); i++)
                send_byte(vecs[v].cipher[47-8*i -: 8], i == int'(vecs[v].len) - 1);
            repeat (3) @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", v), vecs[v].plain, int'(vecs[v].len), 1'b1);
            check($sformatf("vec%0d_frame_done", v), fd_cnt, 1);
            check($sformatf("vec%0d_byte_count", v), mon_bc, {24'd0, vecs[v].len});
        end

        // Output back-pressure with m_ready pattern 1,0,0,1.
        clear_capture();
        load_key(8'hA5);
        stall_chk = 1'b1;
        fork
            begin
                for (int c = 0; c < 24; c++) begin
                    drv_mready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk); #1;
                end
                drv_mready = 1'b1;
            end
            begin
                for (int i = 0; i < 4; i++) send_byte(8'hFF, i == 3);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        stall_chk = 1'b0;
        check_out("stall", 48'h5AB56AD50000, 4, 1'b1);
        check("stall_frame_done", fd_cnt, 1);

        // key_load beats data in ARMED; key_load mid-STREAM only flags key_err.
        clear_capture();
        load_key(8'h01);
        drv_key_load = 1'b1;
        drv_key      = 8'hA5;
        drv_valid    = 1'b1;
        drv_data     = 8'hFF;
        @(negedge clk);
        check("keyload_blocks_ready", mon_sready, 1'b0);
        @(posedge clk); #1;
        drv_key_load = 1'b0;
        check("keyload_no_accept", got_data.size(), 0);
        send_byte(8'hFF, 1'b0);
        check("key_err_before", mon_ke, 1'b0);
        load_key(8'h00);
        @(negedge clk);
        check("key_err_set", mon_ke, 1'b1);
        @(posedge clk); #1;
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_out("keyprio", 48'h5AB56AD50000, 4, 1'b1);
        check("key_err_sticky", mon_ke, 1'b1);

        // Over-length frame on the MAX_LEN=4 instance.
        sel = 1'b1;
        clear_capture();
        @(posedge clk); #1;
        load_key(8'h01);
        for (int i = 0; i < 6; i++) send_byte(8'h00, i == 5);
        repeat (3) @(posedge clk);
        #1;
        check_out("maxlen", 48'h010204080000, 4, 1'b0);
        check("maxlen_frame_done", fd_cnt, 0);
        check("maxlen_len_err", mon_le, 1'b1);
        check("maxlen_byte_count", mon_bc, 16'd6);
        drv_valid = 1'b1;
        @(negedge clk);
        check("maxlen_idle_s_ready", mon_sready, 1'b0);
        @(posedge clk); #1;
        drv_valid = 1'b0;
        sel = 1'b0;
        @(posedge clk); #1;

        // Reset while a plaintext byte is pending.
        clear_capture();
        drv_mready = 1'b0;
        load_key(8'hA5);
        send_byte(8'hFF, 1'b0);
        @(negedge clk);
        check("pre_rst_m_valid", mon_mv, 1'b1);
        check("pre_rst_m_data", mon_md, 8'h5A);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_m_valid",    mon_mv, 1'b0);
        check("mid_rst_m_data",     mon_md, 8'h00);
        check("mid_rst_byte_count", mon_bc, 16'd0);
        check("mid_rst_key_err",    mon_ke, 1'b0);
        check("mid_rst_s_ready",    mon_sready, 1'b0);
        @(posedge clk); #1;
        reset      = 1'b0;
        drv_mready = 1'b1;
        drv_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_s_ready%0d", c), mon_sready, 1'b0);
        end
        drv_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
